// File: rtl/data_sram_if.sv
// Purpose: CPU data-SRAM request/response bundle (en/wen/addr/wdata in, rdata out).
// Latency: rdata is returned by the responder one cycle after a sampled request.
// Backpressure: none; every request presented with en=1 is accepted that cycle.
interface data_sram_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, output wen, output addr, output wdata, input rdata);
  modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/data_sram_resp.sv
// Purpose: data-SRAM responder: byte-writable word RAM plus timer/LED/switch register window.
// Latency: one cycle, read-first (returns the value held before the same-cycle write).
// Backpressure: none; a request is accepted every cycle, reset drops a same-cycle request.
module data_sram_resp #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [15:0] MMIO_BASE  = 16'hbfaf
) (
  input  logic             clk,
  input  logic             rst,
  data_sram_if.slave       bus,
  input  logic [7:0]       switch,
  output logic [15:0]      led,
  output logic [5:0]       ext_int
);

  // Register word offsets (addr[15:2]); byte-offset bits are ignored.
  localparam logic [13:0] OFF_TIMER   = 14'h2000; // 16'h8000
  localparam logic [13:0] OFF_COMPARE = 14'h2001; // 16'h8004
  localparam logic [13:0] OFF_STATUS  = 14'h2002; // 16'h8008
  localparam logic [13:0] OFF_LED     = 14'h3c00; // 16'hf000
  localparam logic [13:0] OFF_SWITCH  = 14'h3c01; // 16'hf004

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  logic [31:0] mem [2**ADDR_WIDTH];

  logic                  win;
  logic [ADDR_WIDTH-1:0] idx;
  logic [13:0]           off;
  logic                  req;
  logic                  ram_rd;
  logic                  ram_wr;
  logic                  reg_wr;
  logic [31:0]           reg_val;
  logic                  unused_addr_lsb;

  logic [31:0] timer_q,     timer_d;
  logic [31:0] compare_q,   compare_d;
  logic        pend_q,      pend_d;
  logic [15:0] led_q,       led_d;
  logic [31:0] reg_rdata_q, reg_rdata_d;
  logic        rd_ram_q,    rd_ram_d;
  logic [31:0] ram_rdata_q;
  logic        cmp_hit;
  logic        clr_pend;

  assign unused_addr_lsb = ^bus.addr[1:0];

  // Address decode; reset suppresses any same-cycle request.
  always_comb begin
    win    = (bus.addr[31:16] == MMIO_BASE);
    idx    = bus.addr[ADDR_WIDTH+1:2];
    off    = bus.addr[15:2];
    req    = bus.en && !rst;
    ram_rd = req && !win;
    ram_wr = req && !win && (bus.wen != 4'b0000);
    reg_wr = req && win && (bus.wen != 4'b0000);
  end

  // Register window read mux, using the pre-update register values (read-first).
  always_comb begin
    reg_val = 32'h0;
    case (off)
      OFF_TIMER:   reg_val = timer_q;
      OFF_COMPARE: reg_val = compare_q;
      OFF_STATUS:  reg_val = {31'h0, pend_q};
      OFF_LED:     reg_val = {16'h0, led_q};
      OFF_SWITCH:  reg_val = {24'h0, switch};
      default:     reg_val = 32'h0;
    endcase
  end

  // Next-state for timer, compare, pending, LED and the registered read path.
  always_comb begin
    timer_d     = timer_q + 32'd1;
    compare_d   = compare_q;
    led_d       = led_q;
    reg_rdata_d = reg_rdata_q;
    rd_ram_d    = rd_ram_q;
    clr_pend    = 1'b0;

    if (reg_wr) begin
      case (off)
        OFF_TIMER:   timer_d   = merge_bytes(timer_q, bus.wdata, bus.wen);
        OFF_COMPARE: compare_d = merge_bytes(compare_q, bus.wdata, bus.wen);
        OFF_STATUS:  clr_pend  = bus.wen[0] && bus.wdata[0];
        OFF_LED:     led_d     = merge_bytes({16'h0, led_q}, bus.wdata, bus.wen) & 32'h0000ffff;
        default:     ;
      endcase
    end

    // Compare against the pre-increment timer; a same-cycle set beats a clear.
    cmp_hit = (timer_q == compare_q) && (compare_q != 32'h0);
    pend_d  = cmp_hit || (pend_q && !clr_pend);

    if (req) begin
      rd_ram_d    = !win;
      reg_rdata_d = win ? reg_val : 32'h0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q     <= 32'h0;
      compare_q   <= 32'h0;
      pend_q      <= 1'b0;
      led_q       <= 16'h0;
      reg_rdata_q <= 32'h0;
      rd_ram_q    <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      compare_q   <= compare_d;
      pend_q      <= pend_d;
      led_q       <= led_d;
      reg_rdata_q <= reg_rdata_d;
      rd_ram_q    <= rd_ram_d;
    end
  end

  // RAM port: synchronous read-first read and per-lane write; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_rd) ram_rdata_q <= mem[idx];
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wen[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  // rd_ram_q steers between the RAM read port and the register read capture;
  // both hold until the next request, so rdata holds too.
  assign bus.rdata = rd_ram_q ? ram_rdata_q : reg_rdata_q;
  assign led       = led_q;
  assign ext_int   = {pend_q, 5'b0};

endmodule

// File: tb/tb_data_sram_resp.sv
// Purpose: directed self-checking bench for data_sram_resp with a read-data scoreboard.
// Latency: expects rdata one cycle after each request.
// Backpressure: none expected; one request is issued per cycle.
module tb_data_sram_resp;
  localparam int          AW        = 12;
  localparam logic [31:0] A_TIMER   = 32'hbfaf8000;
  localparam logic [31:0] A_COMPARE = 32'hbfaf8004;
  localparam logic [31:0] A_STATUS  = 32'hbfaf8008;
  localparam logic [31:0] A_LED     = 32'hbfaff000;
  localparam logic [31:0] A_SWITCH  = 32'hbfaff004;
  localparam logic [31:0] A_UNMAP   = 32'hbfaf1234;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sw_lvl;
  logic [15:0] led;
  logic [5:0]  ext_int;

  data_sram_if bus();

  data_sram_resp #(.ADDR_WIDTH(AW), .MMIO_BASE(16'hbfaf)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .switch  (sw_lvl),
    .led     (led),
    .ext_int (ext_int)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.en    = 1'b0;
    bus.wen   = 4'b0000;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    bus.en    = 1'b1;
    bus.wen   = be;
    bus.addr  = a;
    bus.wdata = d;
  endtask

  // Request with a scoreboarded result (read-first value for writes).
  task automatic xfer(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                      input logic [31:0] expv, input string tag);
    drive(a, be, d);
    exp_q.push_back(expv);
    tick();
    idle();
    check(tag, bus.rdata, exp_q.pop_front());
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    drive(a, be, d);
    tick();
    idle();
  endtask

  initial begin
    rst    = 1'b1;
    sw_lvl = 8'h00;
    idle();

    // Reset state
    tick();
    tick();
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_ext_int", {26'h0, ext_int}, 32'h0);
    rst = 1'b0;
    xfer(A_TIMER, 4'b0000, 32'h0, 32'h0, "timer_first_read");
    xfer(A_TIMER, 4'b0000, 32'h0, 32'h1, "timer_second_read");

    // RAM byte writes and rdata hold
    wr(32'h00000010, 4'b1111, 32'h11223344);
    wr(32'h00000010, 4'b0010, 32'h0000aa00);
    xfer(32'h00000010, 4'b0000, 32'h0, 32'h1122aa44, "ram_byte_merge");
    tick();
    check("rdata_hold", bus.rdata, 32'h1122aa44);

    // Read-first back-to-back and address aliasing
    wr(32'h00000020, 4'b1111, 32'hcafe0001);
    xfer(32'h00000020, 4'b1111, 32'hcafe0002, 32'hcafe0001, "read_first_1");
    xfer(32'h00000020, 4'b1111, 32'hcafe0003, 32'hcafe0002, "read_first_2");
    xfer(32'h00000020 + (32'd4 << AW), 4'b1111, 32'hcafe0004, 32'hcafe0003, "alias_read_first");
    xfer(32'h00000020, 4'b0000, 32'h0, 32'hcafe0004, "alias_visible");

    // LED, SWITCH, unmapped
    wr(A_LED, 4'b1111, 32'hdeadbeef);
    check("led_value", {16'h0, led}, 32'h0000beef);
    xfer(A_LED, 4'b0000, 32'h0, 32'h0000beef, "led_readback");
    wr(A_LED, 4'b0001, 32'h00000012);
    check("led_byte_write", {16'h0, led}, 32'h0000be12);
    sw_lvl = 8'h5a;
    xfer(A_SWITCH, 4'b0000, 32'h0, 32'h0000005a, "switch_read");
    wr(A_SWITCH, 4'b1111, 32'hffffffff);
    xfer(A_SWITCH, 4'b0000, 32'h0, 32'h0000005a, "switch_write_ignored");
    xfer(A_UNMAP, 4'b0000, 32'h0, 32'h0, "unmapped_read");

    // Timer interrupt: rises exactly 11 cycles after the TIMER write edge
    wr(A_COMPARE, 4'b1111, 32'd10);
    wr(A_TIMER, 4'b1111, 32'd0);
    for (int k = 1; k <= 11; k++) begin
      tick();
      check($sformatf("irq_rise_c%0d", k), {31'h0, ext_int[5]}, (k == 11) ? 32'h1 : 32'h0);
    end
    xfer(A_STATUS, 4'b0000, 32'h0, 32'h1, "status_pending");
    wr(A_STATUS, 4'b0001, 32'h1);
    check("irq_cleared", {26'h0, ext_int}, 32'h0);
    xfer(A_STATUS, 4'b0000, 32'h0, 32'h0, "status_clear_read");

    // Same-cycle set and clear: set wins
    wr(A_COMPARE, 4'b1111, 32'd50);
    wr(A_TIMER, 4'b1111, 32'd48);
    tick();
    tick();
    wr(A_STATUS, 4'b0001, 32'h1);
    check("set_beats_clear", {26'h0, ext_int}, 32'h20);
    wr(A_STATUS, 4'b0001, 32'h1);
    check("clear_after_set", {26'h0, ext_int}, 32'h0);

    // COMPARE = 0 never raises pending, even with TIMER passing through 0
    wr(A_COMPARE, 4'b1111, 32'd0);
    wr(A_TIMER, 4'b1111, 32'd0);
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("cmp_zero_c%0d", k), {26'h0, ext_int}, 32'h0);
    end

    // Reset mid-operation
    wr(32'h00000040, 4'b1111, 32'h5555aaaa);
    wr(A_COMPARE, 4'b1111, 32'd5);
    wr(A_TIMER, 4'b1111, 32'd5);
    tick();
    check("pre_reset_irq", {26'h0, ext_int}, 32'h20);
    rst = 1'b1;
    drive(32'h00000040, 4'b0000, 32'h0);
    tick();
    rst = 1'b0;
    idle();
    check("midreset_rdata", bus.rdata, 32'h0);
    check("midreset_led", {16'h0, led}, 32'h0);
    check("midreset_ext_int", {26'h0, ext_int}, 32'h0);
    xfer(A_TIMER, 4'b0000, 32'h0, 32'h0, "midreset_timer");
    xfer(A_COMPARE, 4'b0000, 32'h0, 32'h0, "midreset_compare");
    xfer(32'h00000040, 4'b0000, 32'h0, 32'h5555aaaa, "ram_retained");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
